hdc_class_ctrl: RTL
===================

// Module: hdc_class_ctrl
// PURPOSE
//  Sequencer for the gen_class HDC associative memory. Accepts train/infer commands
//  (query HV, op, label) on a valid/ready port, drives gen_class's en/op/trained_label/in_hv
//  with the one-cycle en pulse plus idle gap gen_class expects, and returns each inference
//  result on a valid/ready port. Keeps saturating train/infer/seizure counters for
//  host readout. Sits between the HV encoder output and gen_class.
// PARAMETERS
//  DIMENSIONS  5   hypervector width; must match the gen_class instance
//  CLASS_LAT   1   cycles from the cls_en pulse until predicted_label is valid; >=1
//  CNT_W       16  width of each statistics counter
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous, active-high reset
//  cmd_valid        in   1           command present
//  cmd_ready        out  1           controller can accept a command
//  cmd_op           in   1           0 = train, 1 = infer
//  cmd_label        in   1           training label (0 non-seizure, 1 seizure); ignored on infer
//  cmd_hv           in   DIMENSIONS  query/training hypervector
//  cls_en           out  1           gen_class en
//  cls_op           out  1           gen_class op
//  cls_label        out  1           gen_class trained_label
//  cls_hv           out  DIMENSIONS  gen_class in_hv
//  predicted_label  in   1           gen_class predicted_label
//  res_valid        out  1           inference result available
//  res_ready        in   1           consumer accepts result
//  res_label        out  1           captured prediction
//  clr_cnt          in   1           synchronous clear of the statistics counters
//  train_cnt        out  CNT_W       accepted train commands, saturating
//  infer_cnt        out  CNT_W       completed inferences (result handshaken), saturating
//  seizure_cnt      out  CNT_W       completed inferences with res_label=1, saturating
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, GAP, WAIT, RESP. On reset: state=IDLE, all outputs and
//    counters 0 except cmd_ready=1. Reset asserted in any state aborts the operation:
//    pending result dropped, no counter update, IDLE next cycle.
//  - cmd_ready = (state==IDLE) and not rst. Accept = cmd_valid & cmd_ready at cycle t.
//    On accept: register cmd_hv/op/label into cls_hv/cls_op/cls_label; go to ISSUE.
//  - ISSUE (t+1): cls_en=1 for exactly this cycle. op=0 -> GAP; op=1 -> WAIT.
//  - GAP (t+2): cls_en=0, then IDLE (cmd_ready=1 at t+3). Train throughput is 1 cmd / 3 cyc.
//  - WAIT: lasts CLASS_LAT cycles (t+2 .. t+1+CLASS_LAT), cls_en=0. On the last WAIT cycle
//    predicted_label is registered into res_label; RESP is entered at t+2+CLASS_LAT.
//  - RESP: res_valid=1, res_label stable until res_valid & res_ready; then IDLE next cycle.
//    res_ready while res_valid=0 is ignored. No new command is accepted in RESP.
//  - cls_hv/cls_op/cls_label hold their last values outside ISSUE (no glitch to 0).
//  - train_cnt +1 on accept of an op=0 command; infer_cnt +1 and seizure_cnt +res_label on
//    the RESP handshake. All saturate at 2^CNT_W-1 (no wrap). clr_cnt has priority over
//    a same-cycle increment (result 0). clr_cnt does not affect the FSM.
//  - cmd_* must be stable only in the accept cycle; later changes have no effect.
// TESTING
//  1 rst 3 cyc, then idle -> cmd_ready=1, cls_en=0, res_valid=0, all counters 0.
//  2 train hv=5'b11111 lbl=1, hv=5'b10001 lbl=0, hv=5'b11111 lbl=1 back-to-back valid ->
//    cls_en pulses exactly 3x, 3 cycles apart, with matching cls_hv/cls_label; train_cnt=3.
//  3 infer hv=5'b11101, CLASS_LAT=1, res_ready=1 -> cls_en at t+1, res_valid at t+3 with
//    res_label = predicted_label sampled at t+2; infer_cnt=1, seizure_cnt += res_label.
//  4 infer with res_ready=0 for 5 cycles -> res_valid/res_label stable, cmd_ready=0, new
//    cmd_valid not accepted; on res_ready=1 -> IDLE next cycle, counters update once.
//  5 rst asserted during WAIT and during RESP -> IDLE next cycle, res_valid=0, no counter change.
//  6 CNT_W=2: 5 train cmds -> train_cnt saturates at 3; clr_cnt coincident with 6th accept -> 0.

Source files
------------

// File: rtl/hdc_class_ctrl.sv
// Command sequencer for the gen_class HDC associative memory: issues one-cycle en
// pulses, collects inference results and keeps saturating usage statistics.
//
//   state  | meaning
//   IDLE   | ready for a command
//   ISSUE  | cls_en pulse to gen_class
//   GAP    | idle cycle after a train pulse
//   WAIT   | waiting CLASS_LAT cycles for predicted_label
//   RESP   | result held until consumer handshake
module hdc_class_ctrl #(
  parameter int DIMENSIONS = 5,
  parameter int CLASS_LAT  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic                  cmd_label,
  input  logic [DIMENSIONS-1:0] cmd_hv,
  output logic                  cls_en,
  output logic                  cls_op,
  output logic                  cls_label,
  output logic [DIMENSIONS-1:0] cls_hv,
  input  logic                  predicted_label,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_label,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      train_cnt,
  output logic [CNT_W-1:0]      infer_cnt,
  output logic [CNT_W-1:0]      seizure_cnt
);

  localparam int LAT_W = (CLASS_LAT > 1) ? $clog2(CLASS_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CLASS_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DIMENSIONS-1:0] hv_q, hv_d;
  logic                  op_q, op_d;
  logic                  lbl_q, lbl_d;
  logic                  res_q, res_d;
  logic [CNT_W-1:0]      train_q, train_d;
  logic [CNT_W-1:0]      infer_q, infer_d;
  logic [CNT_W-1:0]      seiz_q, seiz_d;
  logic                  accept;
  logic                  resp_hs;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign resp_hs   = (state_q == S_RESP) && res_ready;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    hv_d    = hv_q;
    op_d    = op_q;
    lbl_d   = lbl_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hv_d    = cmd_hv;
          op_d    = cmd_op;
          lbl_d   = cmd_label;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_q) begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
      S_WAIT: begin
        // Down-counter reaches zero on the last latency cycle: sample the prediction then.
        if (lat_q == '0) begin
          res_d   = predicted_label;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters saturate; a clear wins over any same-cycle increment.
  always_comb begin
    train_d = train_q;
    infer_d = infer_q;
    seiz_d  = seiz_q;
    if (clr_cnt) begin
      train_d = '0;
      infer_d = '0;
      seiz_d  = '0;
    end else begin
      if (accept && !cmd_op && train_q != CNT_MAX) train_d = train_q + CNT_W'(1);
      if (resp_hs && infer_q != CNT_MAX)           infer_d = infer_q + CNT_W'(1);
      if (resp_hs && res_q && seiz_q != CNT_MAX)   seiz_d  = seiz_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      hv_q    <= '0;
      op_q    <= 1'b0;
      lbl_q   <= 1'b0;
      res_q   <= 1'b0;
      train_q <= '0;
      infer_q <= '0;
      seiz_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      hv_q    <= hv_d;
      op_q    <= op_d;
      lbl_q   <= lbl_d;
      res_q   <= res_d;
      train_q <= train_d;
      infer_q <= infer_d;
      seiz_q  <= seiz_d;
    end
  end

  assign cls_en      = (state_q == S_ISSUE);
  assign cls_op      = op_q;
  assign cls_label   = lbl_q;
  assign cls_hv      = hv_q;
  assign res_valid   = (state_q == S_RESP);
  assign res_label   = res_q;
  assign train_cnt   = train_q;
  assign infer_cnt   = infer_q;
  assign seizure_cnt = seiz_q;

endmodule
